// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, mult/div interlock, branch squash, dmem freeze + watchdog.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STAGES = 1,
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
  input  logic                  ex_mem_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rt_i,
  input  logic [REG_ADDR_W-1:0] if_id_rs_i,
  input  logic [REG_ADDR_W-1:0] if_id_rt_i,
  input  logic                  if_id_uses_rs_i,
  input  logic                  if_id_uses_rt_i,
  input  logic                  if_id_md_op_i,
  input  logic                  id_ex_md_start_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_write_o,
  output logic                  ex_mem_write_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  stall_o,
  output logic                  md_busy_o,
  output logic                  mem_timeout_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
  output logic [31:0]           freeze_cnt_o
);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  md_state_e   state_q, state_d;
  logic [7:0]  md_cnt_q, md_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q;
  logic        freeze, ex_hit, mem_hit, hazard;

  assign freeze = dmem_req_i && !dmem_ready_i;

  // Register $0 is hard-wired, so a load targeting it never creates a dependency.
  assign ex_hit  = id_ex_mem_read_i && (id_ex_rt_i != '0) &&
                   ((id_ex_rt_i == if_id_rs_i && if_id_uses_rs_i) ||
                    (id_ex_rt_i == if_id_rt_i && if_id_uses_rt_i));
  assign mem_hit = (LOAD_STAGES == 2) && ex_mem_mem_read_i && (ex_mem_rt_i != '0) &&
                   ((ex_mem_rt_i == if_id_rs_i && if_id_uses_rs_i) ||
                    (ex_mem_rt_i == if_id_rt_i && if_id_uses_rt_i));
  assign hazard  = ex_hit || mem_hit || (md_busy_o && if_id_md_op_i);

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_write_o  = 1'b1;
    ex_mem_write_o = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    stall_o        = 1'b0;
    if (freeze) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_write_o  = 1'b0;
      ex_mem_write_o = 1'b0;
    end else if (branch_taken_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (hazard) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
      stall_o       = 1'b1;
    end
  end

  // Mult/div occupancy; the counter keeps running through a freeze.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      MD_IDLE: if (id_ex_md_start_i && !freeze && !branch_taken_i) begin
        state_d  = MD_BUSY;
        md_cnt_d = 8'(MD_LATENCY - 1);
      end
      MD_BUSY: begin
        if (md_cnt_q == 8'd0) state_d = MD_IDLE;
        else                  md_cnt_d = md_cnt_q - 8'd1;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy_o = (state_q == MD_BUSY);

  assign wait_cnt_d = !freeze ? 16'd0 :
                      (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (freeze && wait_cnt_d == 16'(MEM_TIMEOUT)) mem_timeout_q <= 1'b1;
    end
  end

  assign mem_timeout_o = mem_timeout_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (stall_o && stall_cnt_q != '1)                          stall_cnt_q  <= stall_cnt_q + 32'd1;
      if ((if_id_flush_o || id_ex_flush_o) && flush_cnt_q != '1) flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (freeze && freeze_cnt_q != '1)                          freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign freeze_cnt_o = freeze_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LOAD_STAGES 1 and 2) checked every cycle against a rule model.
module tb_hazard_ctrl_unit;
  localparam int RW  = 5;
  localparam int MDL = 4;
  localparam int MTO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_ex_mem_read, ex_mem_mem_read, uses_rs, uses_rt, md_op, md_start, br, dreq, drdy;
  logic [RW-1:0] id_ex_rt, ex_mem_rt, rs, rt;
  // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, stall}
  logic [6:0]    c1, c2;
  logic          md1, md2, to1, to2;
  logic [31:0]   sc1, fc1, zc1, sc2, fc2, zc2;

  int n_chk = 0, n_fail = 0;

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .LOAD_STAGES(1), .MD_LATENCY(MDL), .MEM_TIMEOUT(MTO)) u_ls1 (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(id_ex_mem_read), .id_ex_rt_i(id_ex_rt),
    .ex_mem_mem_read_i(ex_mem_mem_read), .ex_mem_rt_i(ex_mem_rt), .if_id_rs_i(rs), .if_id_rt_i(rt),
    .if_id_uses_rs_i(uses_rs), .if_id_uses_rt_i(uses_rt), .if_id_md_op_i(md_op),
    .id_ex_md_start_i(md_start), .branch_taken_i(br), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .pc_write_o(c1[6]), .if_id_write_o(c1[5]), .id_ex_write_o(c1[4]), .ex_mem_write_o(c1[3]),
    .if_id_flush_o(c1[2]), .id_ex_flush_o(c1[1]), .stall_o(c1[0]), .md_busy_o(md1),
    .mem_timeout_o(to1), .stall_cnt_o(sc1), .flush_cnt_o(fc1), .freeze_cnt_o(zc1));

  hazard_ctrl_unit #(.REG_ADDR_W(RW), .LOAD_STAGES(2), .MD_LATENCY(MDL), .MEM_TIMEOUT(MTO)) u_ls2 (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(id_ex_mem_read), .id_ex_rt_i(id_ex_rt),
    .ex_mem_mem_read_i(ex_mem_mem_read), .ex_mem_rt_i(ex_mem_rt), .if_id_rs_i(rs), .if_id_rt_i(rt),
    .if_id_uses_rs_i(uses_rs), .if_id_uses_rt_i(uses_rt), .if_id_md_op_i(md_op),
    .id_ex_md_start_i(md_start), .branch_taken_i(br), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .pc_write_o(c2[6]), .if_id_write_o(c2[5]), .id_ex_write_o(c2[4]), .ex_mem_write_o(c2[3]),
    .if_id_flush_o(c2[2]), .id_ex_flush_o(c2[1]), .stall_o(c2[0]), .md_busy_o(md2),
    .mem_timeout_o(to2), .stall_cnt_o(sc2), .flush_cnt_o(fc2), .freeze_cnt_o(zc2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          md_rem = 0;     // mult/div cycles still to run
  int          wait_n = 0;     // consecutive freeze cycles
  bit          tmo = 0;
  int unsigned m_sc [2], m_fc [2], m_zc;
  bit          model_ok = 0;

  function automatic bit uses_reg(input logic ld, input logic [RW-1:0] dst);
    return ld && dst != 0 && ((dst == rs && uses_rs) || (dst == rt && uses_rt));
  endfunction

  function automatic logic [6:0] model_comb(input int ls);
    bit stl;
    stl = uses_reg(id_ex_mem_read, id_ex_rt) || (ls == 2 && uses_reg(ex_mem_mem_read, ex_mem_rt)) ||
          (md_rem > 0 && md_op);
    if (dreq && !drdy) return 7'b0000000;
    if (br)            return 7'b1111110;
    if (stl)           return 7'b0011011;
    return 7'b1111000;
  endfunction

  function automatic logic [31:0] perf(input int unsigned v);
`ifdef HAZARD_PERF_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    logic [6:0] e [2];
    bit frz;
    if (rst) begin
      md_rem = 0; wait_n = 0; tmo = 0; m_zc = 0;
      for (int i = 0; i < 2; i++) begin m_sc[i] = 0; m_fc[i] = 0; end
      model_ok = 1;
    end else begin
      e[0] = model_comb(1);
      e[1] = model_comb(2);
      frz  = dreq && !drdy;
      for (int i = 0; i < 2; i++) begin
        if (e[i][0] && m_sc[i] != 32'hFFFF_FFFF) m_sc[i]++;
        if ((e[i][2] || e[i][1]) && m_fc[i] != 32'hFFFF_FFFF) m_fc[i]++;
      end
      if (frz && m_zc != 32'hFFFF_FFFF) m_zc++;
      if (md_rem > 0) md_rem--;
      else if (md_start && !frz && !br) md_rem = MDL;
      if (frz) begin
        wait_n++;
        if (wait_n >= MTO) tmo = 1;
      end else wait_n = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("comb_ls1", {25'd0, c1}, {25'd0, model_comb(1)});
      chk("comb_ls2", {25'd0, c2}, {25'd0, model_comb(2)});
      chk("md_busy_ls1", {31'd0, md1}, {31'd0, md_rem > 0});
      chk("md_busy_ls2", {31'd0, md2}, {31'd0, md_rem > 0});
      chk("timeout_ls1", {31'd0, to1}, {31'd0, tmo});
      chk("timeout_ls2", {31'd0, to2}, {31'd0, tmo});
      chk("stall_cnt_ls1", sc1, perf(m_sc[0]));
      chk("stall_cnt_ls2", sc2, perf(m_sc[1]));
      chk("flush_cnt_ls1", fc1, perf(m_fc[0]));
      chk("flush_cnt_ls2", fc2, perf(m_fc[1]));
      chk("freeze_cnt_ls1", zc1, perf(m_zc));
      chk("freeze_cnt_ls2", zc2, perf(m_zc));
    end
  end

  // ---------------- directed stimulus with literal pins ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_ex_mem_read = 0; ex_mem_mem_read = 0; uses_rs = 0; uses_rt = 0; md_op = 0;
    md_start = 0; br = 0; dreq = 0; drdy = 0;
    id_ex_rt = 0; ex_mem_rt = 0; rs = 0; rt = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    settle();
    chk("rst_md_busy", {31'd0, md2}, 32'd0);
    chk("rst_timeout", {31'd0, to2}, 32'd0);
    chk("rst_stall_cnt", sc2, 32'd0);
    chk("rst_idle_comb", {25'd0, c2}, 32'h78);
    rst = 0;
    tick();

    // lw $5 in EX, add in ID reads $5 through rs
    id_ex_mem_read = 1; id_ex_rt = 5; rs = 5; uses_rs = 1; settle();
    chk("lu_stall", {31'd0, c1[0]}, 32'd1);
    chk("lu_pc_write", {31'd0, c1[6]}, 32'd0);
    chk("lu_if_id_write", {31'd0, c1[5]}, 32'd0);
    chk("lu_id_ex_flush", {31'd0, c1[1]}, 32'd1);
    tick();
    idle(); id_ex_mem_read = 1; id_ex_rt = 0; rs = 0; uses_rs = 1; settle();
    chk("lu_r0_nostall", {31'd0, c2[0]}, 32'd0);
    tick();
    idle(); id_ex_mem_read = 1; id_ex_rt = 9; rt = 9; uses_rt = 1; settle();
    chk("lu_rt_stall", {31'd0, c2[0]}, 32'd1);
    tick();
    uses_rt = 0; settle();
    chk("lu_rt_unused", {31'd0, c2[0]}, 32'd0);
    tick();

    // load $7 in MEM: only the two-stage checker cares
    idle(); ex_mem_mem_read = 1; ex_mem_rt = 7; rs = 7; uses_rs = 1; settle();
    chk("mem_hit_ls2", {31'd0, c2[0]}, 32'd1);
    chk("mem_hit_ls1", {31'd0, c1[0]}, 32'd0);
    tick();
    ex_mem_mem_read = 0; settle();
    chk("mem_noload_ls2", {31'd0, c2[0]}, 32'd0);
    tick();

    // mult accepted in cycle 0, mflo in ID from cycle 2
    idle(); md_start = 1; tick();
    md_start = 0;
    for (int c = 1; c <= 5; c++) begin
      md_op = (c >= 2);
      settle();
      chk($sformatf("md_busy_c%0d", c), {31'd0, md2}, {31'd0, c <= 4});
      if (c >= 2) chk($sformatf("md_stall_c%0d", c), {31'd0, c2[0]}, {31'd0, c <= 4});
      tick();
    end
    idle(); md_start = 1; br = 1; tick();
    idle(); settle();
    chk("md_start_squashed", {31'd0, md2}, 32'd0);
    tick();

    // freeze with a pending branch and a load-use hit
    idle(); dreq = 1; drdy = 0; br = 1; id_ex_mem_read = 1; id_ex_rt = 3; rs = 3; uses_rs = 1;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk($sformatf("freeze_c%0d", c), {25'd0, c2}, 32'd0);
      tick();
    end
    drdy = 1; settle();
    chk("unfreeze_if_id_flush", {31'd0, c2[2]}, 32'd1);
    chk("unfreeze_id_ex_flush", {31'd0, c2[1]}, 32'd1);
    chk("unfreeze_pc_write", {31'd0, c2[6]}, 32'd1);
    chk("unfreeze_stall", {31'd0, c2[0]}, 32'd0);
    tick();

    // watchdog: 4 waits stay quiet, 5 waits trip the sticky flag
    idle(); dreq = 1;
    repeat (MTO - 1) tick();
    drdy = 1; settle();
    chk("timeout_below", {31'd0, to2}, 32'd0);
    tick();
    drdy = 0;
    repeat (MTO) tick();
    drdy = 1; settle();
    chk("timeout_hit", {31'd0, to2}, 32'd1);
    tick();
    idle(); tick(); tick(); settle();
    chk("timeout_sticky", {31'd0, to1}, 32'd1);
    rst = 1; tick();
    rst = 0; settle();
    chk("timeout_rst", {31'd0, to1}, 32'd0);

    // performance counters: two branches, then three load-use stalls
    br = 1; tick(); tick();
    br = 0; settle();
    chk("perf_flush_2br", fc2, perf(2));
    chk("perf_stall_0", sc2, 32'd0);
    id_ex_mem_read = 1; id_ex_rt = 4; rt = 4; uses_rt = 1;
    tick(); tick(); tick();
    idle(); settle();
    chk("perf_stall_3", sc1, perf(3));
    tick();

    // reset in the middle of a mult/div
    md_start = 1; tick();
    md_start = 0; tick(); settle();
    chk("mid_busy", {31'd0, md2}, 32'd1);
    rst = 1; tick();
    rst = 0; settle();
    chk("busy_after_rst", {31'd0, md2}, 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
